// File: rtl/input_filter.sv
// input_filter: synchroniser plus stable-count debouncer for one raw switch line.
// Optional rejected-glitch counter is built when INPUT_FILTER_GLITCH_CNT_EN is defined.
module input_filter #(
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 16,
   parameter logic RESET_LEVEL   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   output logic       out,
   output logic       changed
`ifdef INPUT_FILTER_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   out_q, out_d;
   logic                   changed_q, changed_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // Any cycle where s matches out clears progress; there is no partial credit.
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], in};
      out_d     = out_q;
      cnt_d     = '0;
      changed_d = 1'b0;
      if (s != out_q) begin
         if (cnt_q == CNT_LAST) begin
            out_d     = s;
            changed_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= {SYNC_STAGES{RESET_LEVEL}};
         cnt_q     <= '0;
         out_q     <= RESET_LEVEL;
         changed_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         changed_q <= changed_d;
      end
   end

   assign out     = out_q;
   assign changed = changed_q;

`ifdef INPUT_FILTER_GLITCH_CNT_EN
   logic [7:0] glitch_q, glitch_d;

   // A glitch is a run of differing cycles that ended before acceptance.
   always_comb begin
      glitch_d = glitch_q;
      if ((s == out_q) && (cnt_q != '0) && (glitch_q != 8'hFF)) begin
         glitch_d = glitch_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch_q <= 8'd0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_input_filter.sv
// Bench for input_filter: directed scenarios plus random runs against a history-based model.
module tb_input_filter;

   localparam int SYNC = 2;
   localparam int STAB = 16;
   localparam bit RL   = 1'b0;

   logic clk = 1'b0;
   logic rst, in_r, out_w, changed_w;
   logic rst_c, in_c, out_c, changed_c;
`ifdef INPUT_FILTER_GLITCH_CNT_EN
   logic [7:0] glitch_w, glitch_c;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   input_filter #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .RESET_LEVEL(RL)) u_dut (
      .clk(clk), .rst(rst), .in(in_r), .out(out_w), .changed(changed_w)
`ifdef INPUT_FILTER_GLITCH_CNT_EN
      , .glitch_cnt(glitch_w)
`endif
   );

   input_filter #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .RESET_LEVEL(1'b1)) u_corner (
      .clk(clk), .rst(rst_c), .in(in_c), .out(out_c), .changed(changed_c)
`ifdef INPUT_FILTER_GLITCH_CNT_EN
      , .glitch_cnt(glitch_c)
`endif
   );

   // Model: out flips at edge k when the last STAB synchronised samples all
   // differ from out and no flip happened inside that window.
   bit hist[$];
   int medge, mlast, mglitch;
   bit mout, mchg;

   function automatic bit s_at(int k);
      int e = k - SYNC;
      if (e < 1) return RL;
      return hist[e-1];
   endfunction

   function automatic void m_reset();
      hist.delete();
      medge = 0; mlast = 0; mglitch = 0; mout = RL; mchg = 0;
   endfunction

   function automatic void m_edge(bit v);
      bit flip = 1'b1;
      hist.push_back(v);
      medge++;
      if (medge - mlast < STAB) flip = 1'b0;
      else for (int j = medge - STAB + 1; j <= medge; j++) if (s_at(j) == mout) flip = 1'b0;
      if (!flip && (medge - 1 > mlast) && (s_at(medge-1) != mout) && (s_at(medge) == mout)
          && (mglitch < 255)) mglitch++;
      mchg = flip;
      if (flip) begin
         mout  = !mout;
         mlast = medge;
      end
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) m_reset();
      else m_edge(in_r);
      #1;
      chk("out", 32'(out_w), 32'(mout));
      chk("changed", 32'(changed_w), 32'(mchg));
`ifdef INPUT_FILTER_GLITCH_CNT_EN
      chk("glitch_cnt", 32'(glitch_w), 32'(mglitch));
`endif
   endtask

   task automatic hold(bit v, int n);
      in_r = v;
      repeat (n) tick();
   endtask

   // Counts edges until the first changed pulse and the number of pulses in 40 edges.
   task automatic latency(string tag);
      int n = 0;
      int pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (changed_w === 1'b1) begin
            pulses++;
            if (n == 0) n = i;
         end
      end
      chk({tag, "_latency"}, n, SYNC + STAB);
      chk({tag, "_pulses"}, pulses, 1);
   endtask

   initial begin
      int g0;
      int n;
      rst = 1'b1; in_r = 1'b1; rst_c = 1'b1; in_c = 1'b0;
      m_reset();

      // Reset holds out low despite in=1, then full latency after release.
      repeat (4) tick();
      chk("reset_out", 32'(out_w), 32'(RL));
      chk("reset_changed", 32'(changed_w), 0);
      rst = 1'b0;
      latency("rst_release");
      chk("after_release_out", 32'(out_w), 1);

      // Clean release and press, mirror timing.
      in_r = 1'b0;
      latency("fall");
      chk("fall_out", 32'(out_w), 0);
      in_r = 1'b1;
      latency("rise");
      in_r = 1'b0;
      latency("fall2");

      // Single glitch of 5 cycles.
`ifdef INPUT_FILTER_GLITCH_CNT_EN
      g0 = int'(glitch_w);
`endif
      hold(1'b1, 5);
      hold(1'b0, 30);
      chk("glitch_out", 32'(out_w), 0);
`ifdef INPUT_FILTER_GLITCH_CNT_EN
      chk("glitch_one", 32'(glitch_w), 32'(g0 + 1));
`endif

      // Bounce train, then steady 1.
`ifdef INPUT_FILTER_GLITCH_CNT_EN
      g0 = int'(glitch_w);
`endif
      hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 3); hold(1'b0, 2);
      hold(1'b1, 1); hold(1'b0, 3);
      in_r = 1'b1;
      latency("bounce");
`ifdef INPUT_FILTER_GLITCH_CNT_EN
      chk("bounce_glitches", 32'(glitch_w), 32'(g0 + 3));
`endif

      // Reset mid-count: async assert returns out to RESET_LEVEL at once.
      hold(1'b0, 40);
      hold(1'b1, 10);
      #2 rst = 1'b1;
      #1 chk("midrst_out", 32'(out_w), 32'(RL));
      chk("midrst_changed", 32'(changed_w), 0);
      tick(); tick();
      rst = 1'b0;
      latency("midrst_release");

      // Random runs against the model.
      for (int r = 0; r < 60; r++) hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 25)));
      hold(1'b0, 40);
      chk("random_settle_out", 32'(out_w), 0);

      // Glitch counter saturation.
      for (int i = 0; i < 300; i++) begin
         hold(1'b1, 1);
         hold(1'b0, 1);
      end
      hold(1'b0, 5);
      chk("sat_out", 32'(out_w), 0);
`ifdef INPUT_FILTER_GLITCH_CNT_EN
      chk("sat_glitch", 32'(glitch_w), 32'hFF);
`endif

      // Corner instance: SYNC_STAGES=3, STABLE_CYCLES=1, RESET_LEVEL=1.
      chk("corner_reset_out", 32'(out_c), 1);
      chk("corner_reset_changed", 32'(changed_c), 0);
      in_c = 1'b1;
      rst_c = 1'b0;
      repeat (6) tick();
      chk("corner_hold_out", 32'(out_c), 1);
      in_c = 1'b0;
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (n == 0 && out_c === 1'b0) begin
            n = i;
            chk("corner_changed", 32'(changed_c), 1);
         end
      end
      chk("corner_latency", n, 4);
      in_c = 1'b1;
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (n == 0 && out_c === 1'b1) n = i;
      end
      chk("corner_rise_latency", n, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
